// File: rtl/irq_controller.sv
// irq_controller: masked, fixed-priority interrupt controller feeding the
// trap interface of csr_controller. One interrupt is in service at a time:
// a winner is latched in IDLE, a one-cycle trap pulse is issued, the block
// waits for mret, then returns a one-hot acknowledge to the serviced source.
module irq_controller #(
  parameter int IRQ_NUM    = 16,
  parameter int CAUSE_BASE = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [IRQ_NUM-1:0] irq_req_i,
  input  logic [31:0]        mie_i,
  input  logic               exception_i,
  input  logic               mret_i,
  output logic               irq_o,
  output logic [31:0]        irq_cause_o,
  output logic [IRQ_NUM-1:0] irq_ret_o
);

  localparam int IDX_W = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RET   = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [IRQ_NUM-1:0] pending;
  logic               any_pending;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   idx_q;
  logic               latch_en;
  logic [IRQ_NUM-1:0] ack_onehot;
  logic [31:0]        cause_nxt;

  // Only the low IRQ_NUM enable bits matter; fold the rest into a sink.
  generate
    if (IRQ_NUM < 32) begin : g_mie_sink
      logic unused_mie;
      assign unused_mie = ^mie_i[31:IRQ_NUM];
    end
  endgenerate

  assign pending     = irq_req_i & mie_i[IRQ_NUM-1:0];
  assign any_pending = |pending;

  // Priority encoder: scan high to low so the lowest set index wins.
  always_comb begin
    win_idx = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (pending[i]) win_idx = IDX_W'(i);
    end
  end

  // Bit 31 flags an interrupt; the low bits carry CAUSE_BASE + index.
  assign cause_nxt = 32'h8000_0000 | (32'(CAUSE_BASE) + 32'(win_idx));

  // One-hot acknowledge vector for the latched source.
  always_comb begin
    ack_onehot = '0;
    for (int i = 0; i < IRQ_NUM; i++) begin
      ack_onehot[i] = (idx_q == IDX_W'(i));
    end
  end

  // Next-state logic. Exceptions pre-empt the latch only in IDLE; BUSY
  // ignores everything except mret, so there is no nesting.
  always_comb begin
    state_nxt = state;
    latch_en  = 1'b0;
    case (state)
      IDLE: begin
        if (any_pending && !exception_i) begin
          latch_en  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = BUSY;
      BUSY: begin
        if (mret_i) state_nxt = RET;
      end
      RET: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, latched index and registered outputs. Outputs are computed from
  // the next state so each pulse lines up with its state cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      idx_q       <= '0;
      irq_o       <= 1'b0;
      irq_cause_o <= 32'h0;
      irq_ret_o   <= '0;
    end else begin
      state     <= state_nxt;
      irq_o     <= (state_nxt == ISSUE);
      irq_ret_o <= (state_nxt == RET) ? ack_onehot : '0;
      if (latch_en) begin
        idx_q       <= win_idx;
        irq_cause_o <= cause_nxt;
      end
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller. Inputs change 1 ns after a rising
// edge; outputs are sampled at the same point, i.e. the cycle after the
// edge that produced them.
module tb_irq_controller;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] irq_req_i;
  logic [31:0] mie_i;
  logic        exception_i;
  logic        mret_i;
  logic        irq_o;
  logic [31:0] irq_cause_o;
  logic [15:0] irq_ret_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk_i = ~clk_i;

  irq_controller #(.IRQ_NUM(16), .CAUSE_BASE(16)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .irq_req_i   (irq_req_i),
    .mie_i       (mie_i),
    .exception_i (exception_i),
    .mret_i      (mret_i),
    .irq_o       (irq_o),
    .irq_cause_o (irq_cause_o),
    .irq_ret_o   (irq_ret_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; irq_req_i = 16'hFFFF; mie_i = 32'hFFFF;
    exception_i = 1'b0; mret_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      total_cnt++;
      if (irq_o !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq_o);
      else pass_cnt++;
      total_cnt++;
      if (irq_cause_o !== 32'h0) $display("FAIL reset_cause: got %h want 0", irq_cause_o);
      else pass_cnt++;
      total_cnt++;
      if (irq_ret_o !== 16'h0) $display("FAIL reset_ret: got %h want 0", irq_ret_o);
      else pass_cnt++;
    end
    irq_req_i = 16'h0; mie_i = 32'h0;
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_single();
    irq_req_i = 16'h0020; mie_i = 32'h0020;
    step();
    total_cnt++;
    if (irq_o !== 1'b1) $display("FAIL single_irq: got %b want 1", irq_o);
    else pass_cnt++;
    total_cnt++;
    if (irq_cause_o !== 32'h8000_0015) $display("FAIL single_cause: got %h want 80000015", irq_cause_o);
    else pass_cnt++;
    step();
    total_cnt++;
    if (irq_o !== 1'b0) $display("FAIL single_irq_width: got %b want 0", irq_o);
    else pass_cnt++;
    step();
    mret_i = 1'b1;
    step();
    mret_i = 1'b0; irq_req_i = 16'h0;
    total_cnt++;
    if (irq_ret_o !== 16'h0020) $display("FAIL single_ack: got %h want 0020", irq_ret_o);
    else pass_cnt++;
    step();
    total_cnt++;
    if (irq_ret_o !== 16'h0) $display("FAIL single_ack_width: got %h want 0", irq_ret_o);
    else pass_cnt++;
    total_cnt++;
    if (irq_cause_o !== 32'h8000_0015) $display("FAIL single_cause_hold: got %h want 80000015", irq_cause_o);
    else pass_cnt++;
    step();
  endtask

  task automatic test_priority_mask();
    irq_req_i = 16'h8006; mie_i = 32'h8004;
    step();
    total_cnt++;
    if (irq_o !== 1'b1 || irq_cause_o !== 32'h8000_0012)
      $display("FAIL prio_first: got irq=%b cause=%h want irq=1 cause=80000012", irq_o, irq_cause_o);
    else pass_cnt++;
    step();
    mret_i = 1'b1;
    step();
    mret_i = 1'b0; irq_req_i = 16'h8002;
    total_cnt++;
    if (irq_ret_o !== 16'h0004) $display("FAIL prio_ack1: got %h want 0004", irq_ret_o);
    else pass_cnt++;
    step();
    total_cnt++;
    if (irq_o !== 1'b0) $display("FAIL prio_gap: got %b want 0", irq_o);
    else pass_cnt++;
    step();
    total_cnt++;
    if (irq_o !== 1'b1 || irq_cause_o !== 32'h8000_001F)
      $display("FAIL prio_second: got irq=%b cause=%h want irq=1 cause=8000001f", irq_o, irq_cause_o);
    else pass_cnt++;
    step();
    mret_i = 1'b1;
    step();
    mret_i = 1'b0; irq_req_i = 16'h0;
    total_cnt++;
    if (irq_ret_o !== 16'h8000) $display("FAIL prio_ack2: got %h want 8000", irq_ret_o);
    else pass_cnt++;
    step();
    step();
  endtask

  task automatic test_exception_nesting();
    irq_req_i = 16'h0008; mie_i = 32'hFFFF; exception_i = 1'b1;
    step();
    exception_i = 1'b0;
    total_cnt++;
    if (irq_o !== 1'b0) $display("FAIL exc_block: got %b want 0", irq_o);
    else pass_cnt++;
    step();
    total_cnt++;
    if (irq_o !== 1'b1 || irq_cause_o !== 32'h8000_0013)
      $display("FAIL exc_after: got irq=%b cause=%h want irq=1 cause=80000013", irq_o, irq_cause_o);
    else pass_cnt++;
    // In service: a higher-priority source and an exception must be ignored.
    irq_req_i = 16'h0009; exception_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      total_cnt++;
      if (irq_o !== 1'b0) $display("FAIL nest_irq[%0d]: got %b want 0", c, irq_o);
      else pass_cnt++;
    end
    exception_i = 1'b0; mret_i = 1'b1;
    step();
    mret_i = 1'b0; irq_req_i = 16'h0001;
    total_cnt++;
    if (irq_ret_o !== 16'h0008) $display("FAIL nest_ack: got %h want 0008", irq_ret_o);
    else pass_cnt++;
    step();
    step();
    total_cnt++;
    if (irq_o !== 1'b1 || irq_cause_o !== 32'h8000_0010)
      $display("FAIL nest_next: got irq=%b cause=%h want irq=1 cause=80000010", irq_o, irq_cause_o);
    else pass_cnt++;
    step();
    mret_i = 1'b1;
    step();
    mret_i = 1'b0; irq_req_i = 16'h0;
    total_cnt++;
    if (irq_ret_o !== 16'h0001) $display("FAIL nest_ack0: got %h want 0001", irq_ret_o);
    else pass_cnt++;
    step();
    step();
  endtask

  task automatic test_stray_mret();
    mret_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      total_cnt++;
      if (irq_ret_o !== 16'h0 || irq_o !== 1'b0)
        $display("FAIL idle_mret[%0d]: got ret=%h irq=%b want 0/0", c, irq_ret_o, irq_o);
      else pass_cnt++;
    end
    mret_i = 1'b0; irq_req_i = 16'h0010;
    step();
    // mret sampled while in ISSUE is dropped.
    mret_i = 1'b1;
    step();
    mret_i = 1'b0;
    total_cnt++;
    if (irq_ret_o !== 16'h0) $display("FAIL issue_mret: got %h want 0", irq_ret_o);
    else pass_cnt++;
    step();
    total_cnt++;
    if (irq_ret_o !== 16'h0) $display("FAIL issue_mret_late: got %h want 0", irq_ret_o);
    else pass_cnt++;
    mret_i = 1'b1;
    step();
    mret_i = 1'b0; irq_req_i = 16'h0;
    total_cnt++;
    if (irq_ret_o !== 16'h0010) $display("FAIL busy_mret_ack: got %h want 0010", irq_ret_o);
    else pass_cnt++;
    step();
    step();
  endtask

  task automatic test_reset_busy();
    irq_req_i = 16'h0002;
    step();
    total_cnt++;
    if (irq_o !== 1'b1) $display("FAIL rb_irq: got %b want 1", irq_o);
    else pass_cnt++;
    step();
    rst_i = 1'b1; mret_i = 1'b1;
    step();
    rst_i = 1'b0; mret_i = 1'b0;
    total_cnt++;
    if (irq_ret_o !== 16'h0 || irq_o !== 1'b0 || irq_cause_o !== 32'h0)
      $display("FAIL rb_reset: got ret=%h irq=%b cause=%h want 0/0/0", irq_ret_o, irq_o, irq_cause_o);
    else pass_cnt++;
    step();
    total_cnt++;
    if (irq_o !== 1'b1 || irq_cause_o !== 32'h8000_0011 || irq_ret_o !== 16'h0)
      $display("FAIL rb_reissue: got irq=%b cause=%h ret=%h want 1/80000011/0", irq_o, irq_cause_o, irq_ret_o);
    else pass_cnt++;
    step();
    mret_i = 1'b1;
    step();
    mret_i = 1'b0; irq_req_i = 16'h0;
    total_cnt++;
    if (irq_ret_o !== 16'h0002) $display("FAIL rb_ack: got %h want 0002", irq_ret_o);
    else pass_cnt++;
    step();
    step();
  endtask

  initial begin
    rst_i = 1'b1; irq_req_i = '0; mie_i = '0; exception_i = 1'b0; mret_i = 1'b0;
    test_reset();
    test_single();
    test_priority_mask();
    test_exception_nesting();
    test_stray_mret();
    test_reset_busy();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
